ex_mem_reg: RTL and testbench

EX_MEM_REG -- requirements
Module: ex_mem_reg

---
 rtl/ex_mem_reg_pkg.sv | 22 ++
 rtl/ex_mem_reg_if.sv | 52 +++++
 rtl/ex_mem_reg_pipe_reg.sv | 24 ++
 rtl/ex_mem_reg.sv | 119 +++++++++++
 tb/tb_ex_mem_reg.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared constants and types for the EX/MEM pipeline register
// Holds the opcode encodings the register decodes, the RUN/HALT state type
// and the default datapath width used by the interface and the top.
package ex_mem_reg_pkg;

    localparam int DATA_W_DEFAULT = 16;

    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // True for opcodes that access data memory (loads and stores).
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/ex_mem_reg_if.sv
// rtl/ex_mem_reg_if.sv - EX-side inputs and MEM-side outputs of the EX/MEM register
// master : pipeline control (stall, flush) and the EX instruction fields in,
//          ex_ready, registered mem_* fields, halted and bubble_cnt out.
// slave  : the EX/MEM register itself (directions mirrored).
interface ex_mem_reg_if
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) ();

    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [3:0]        ex_opcode;
    logic [3:0]        ex_srcreg1;
    logic [3:0]        ex_dstreg;
    logic [DATA_W-1:0] ex_regread1;
    logic [DATA_W-1:0] ex_aluout;
    logic [DATA_W-1:0] ex_pc;
    logic              ex_regwrite_en;
    logic              ex_ready;

    logic              mem_valid;
    logic              Mem_En;
    logic              Mem_Wr;
    logic              mem_regwrite;
    logic [3:0]        mem_opcode;
    logic [3:0]        mem_srcreg1;
    logic [3:0]        mem_dstreg;
    logic [DATA_W-1:0] mem_regread1;
    logic [DATA_W-1:0] mem_aluout;
    logic [DATA_W-1:0] mem_pc;
    logic              halted;
    logic [15:0]       bubble_cnt;

    modport master (
        output stall, flush, ex_valid, ex_opcode, ex_srcreg1, ex_dstreg,
               ex_regread1, ex_aluout, ex_pc, ex_regwrite_en,
        input  ex_ready, mem_valid, Mem_En, Mem_Wr, mem_regwrite,
               mem_opcode, mem_srcreg1, mem_dstreg, mem_regread1,
               mem_aluout, mem_pc, halted, bubble_cnt
    );

    modport slave (
        input  stall, flush, ex_valid, ex_opcode, ex_srcreg1, ex_dstreg,
               ex_regread1, ex_aluout, ex_pc, ex_regwrite_en,
        output ex_ready, mem_valid, Mem_En, Mem_Wr, mem_regwrite,
               mem_opcode, mem_srcreg1, mem_dstreg, mem_regread1,
               mem_aluout, mem_pc, halted, bubble_cnt
    );

endinterface

// File: rtl/ex_mem_reg_pipe_reg.sv
// rtl/ex_mem_reg_pipe_reg.sv - width-parameterised register with load enable and async clear
// clk   : rising-edge clock
// rst_n : asynchronous active-low clear to zero
// en_i  : load d_i on the next rising edge
// d_i   : next value, q_o : registered value
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall, deferred flush and halt
// clk  : rising-edge clock
// rst  : asynchronous active-low reset
// bus  : slave side of ex_mem_reg_if (EX fields and stall/flush in,
//        registered MEM fields, ex_ready, halted, bubble_cnt out)
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    ex_mem_reg_if.slave  bus
);

    localparam int PIPE_W = 12 + 3 * DATA_W;

    state_e      state_q, state_d;
    logic        pend_q, pend_d;
    logic        valid_q, valid_d;
    logic        en_q, en_d;
    logic        wr_q, wr_d;
    logic        rw_q, rw_d;
    logic [15:0] bubble_q, bubble_d;

    logic              load;
    logic              take;
    logic [PIPE_W-1:0] pipe_d;
    logic [PIPE_W-1:0] pipe_q;

    // A stalled edge freezes everything; any other edge is a load edge.
    // The EX instruction is only taken while running and when no flush,
    // live or deferred, is being applied on this edge.
    assign load = ~bus.stall;
    assign take = load && (state_q == ST_RUN) && !bus.flush && !pend_q;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        valid_d  = valid_q;
        en_d     = en_q;
        wr_d     = wr_q;
        rw_d     = rw_q;
        bubble_d = bubble_q;

        if (!load) begin
            // Remember a flush seen while stalled so it is not lost.
            if (bus.flush) begin
                pend_d = 1'b1;
            end
        end else begin
            pend_d = 1'b0;
            if (take) begin
                valid_d = bus.ex_valid;
                en_d    = bus.ex_valid && is_mem_op(bus.ex_opcode);
                wr_d    = bus.ex_valid && (bus.ex_opcode == OP_SW);
                rw_d    = bus.ex_valid && bus.ex_regwrite_en;
                if (bus.ex_valid && (bus.ex_opcode == OP_HLT)) begin
                    state_d = ST_HALT;
                end
            end else begin
                valid_d = 1'b0;
                en_d    = 1'b0;
                wr_d    = 1'b0;
                rw_d    = 1'b0;
            end
            if (!valid_d) begin
                bubble_d = bubble_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            en_q     <= 1'b0;
            wr_q     <= 1'b0;
            rw_q     <= 1'b0;
            bubble_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            en_q     <= en_d;
            wr_q     <= wr_d;
            rw_q     <= rw_d;
            bubble_q <= bubble_d;
        end
    end

    // Data fields hold through bubbles; they only move when an
    // instruction is actually taken from EX.
    assign pipe_d = {bus.ex_opcode, bus.ex_srcreg1, bus.ex_dstreg,
                     bus.ex_regread1, bus.ex_aluout, bus.ex_pc};

    pipe_reg #(
        .W (PIPE_W)
    ) u_data (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (take),
        .d_i   (pipe_d),
        .q_o   (pipe_q)
    );

    assign {bus.mem_opcode, bus.mem_srcreg1, bus.mem_dstreg,
            bus.mem_regread1, bus.mem_aluout, bus.mem_pc} = pipe_q;

    assign bus.mem_valid    = valid_q;
    assign bus.Mem_En       = en_q;
    assign bus.Mem_Wr       = wr_q;
    assign bus.mem_regwrite = rw_q;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.bubble_cnt   = bubble_q;
    assign bus.ex_ready     = (state_q == ST_RUN) && !bus.stall && !pend_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg against a behavioural model
module tb_ex_mem_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;

    always #5 clk = ~clk;

    ex_mem_reg_if #(.DATA_W(16)) bus ();

    ex_mem_reg #(.DATA_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: what the MEM side must hold after each edge.
    bit        m_halt = 0;
    bit        m_pend = 0;
    bit        m_valid = 0, m_en = 0, m_wr = 0, m_rw = 0;
    bit [3:0]  m_op = 0, m_src = 0, m_dst = 0;
    bit [15:0] m_rd = 0, m_alu = 0, m_pc = 0;
    int        m_bc = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_halt = 0; m_pend = 0;
            m_valid = 0; m_en = 0; m_wr = 0; m_rw = 0;
            m_op = 0; m_src = 0; m_dst = 0; m_rd = 0; m_alu = 0; m_pc = 0;
            m_bc = 0;
        end else if (bus.stall) begin
            if (bus.flush) m_pend = 1;
        end else begin
            bit accept;
            accept = !m_halt && !bus.flush && !m_pend;
            m_pend = 0;
            if (accept) begin
                m_op  = bus.ex_opcode;  m_src = bus.ex_srcreg1; m_dst = bus.ex_dstreg;
                m_rd  = bus.ex_regread1; m_alu = bus.ex_aluout; m_pc = bus.ex_pc;
                m_valid = bus.ex_valid;
                m_en  = bus.ex_valid && (bus.ex_opcode == 4'd8 || bus.ex_opcode == 4'd9);
                m_wr  = bus.ex_valid && (bus.ex_opcode == 4'd9);
                m_rw  = bus.ex_valid && bus.ex_regwrite_en;
                if (bus.ex_valid && bus.ex_opcode == 4'd15) m_halt = 1;
            end else begin
                m_valid = 0; m_en = 0; m_wr = 0; m_rw = 0;
            end
            if (!m_valid) m_bc = (m_bc + 1) % 65536;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("ex_ready", 64'(bus.ex_ready), 64'(!m_halt && !bus.stall && !m_pend));
            chk("mem_valid", 64'(bus.mem_valid), 64'(m_valid));
            chk("Mem_En", 64'(bus.Mem_En), 64'(m_en));
            chk("Mem_Wr", 64'(bus.Mem_Wr), 64'(m_wr));
            chk("mem_regwrite", 64'(bus.mem_regwrite), 64'(m_rw));
            chk("mem_opcode", 64'(bus.mem_opcode), 64'(m_op));
            chk("mem_srcreg1", 64'(bus.mem_srcreg1), 64'(m_src));
            chk("mem_dstreg", 64'(bus.mem_dstreg), 64'(m_dst));
            chk("mem_regread1", 64'(bus.mem_regread1), 64'(m_rd));
            chk("mem_aluout", 64'(bus.mem_aluout), 64'(m_alu));
            chk("mem_pc", 64'(bus.mem_pc), 64'(m_pc));
            chk("halted", 64'(bus.halted), 64'(m_halt));
            chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(m_bc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input bit fl, input bit v, input bit [3:0] op,
                         input bit [15:0] rd, input bit [15:0] alu, input bit rw);
        bus.stall = st; bus.flush = fl; bus.ex_valid = v; bus.ex_opcode = op;
        bus.ex_srcreg1 = 4'(op + 4'd3); bus.ex_dstreg = 4'(op ^ 4'd5);
        bus.ex_regread1 = rd; bus.ex_aluout = alu; bus.ex_pc = 16'(alu + 16'd2);
        bus.ex_regwrite_en = rw;
    endtask

    // Asserts reset between edges and confirms outputs clear without a clock.
    task automatic mid_reset(input string nm);
        #2 rst = 1'b0;
        #1;
        chk({nm, "_valid"}, 64'(bus.mem_valid), 0);
        chk({nm, "_wr"}, 64'(bus.Mem_Wr), 0);
        chk({nm, "_halted"}, 64'(bus.halted), 0);
        chk({nm, "_data"}, 64'({bus.mem_opcode, bus.mem_regread1, bus.mem_aluout, bus.mem_pc}), 0);
        chk({nm, "_bc"}, 64'(bus.bubble_cnt), 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        int base;
        drive(0, 0, 0, 4'd0, 16'd0, 16'd0, 0);
        tick(); tick();
        chk("rst_valid", 64'(bus.mem_valid), 0);
        chk("rst_halted", 64'(bus.halted), 0);
        chk("rst_bc", 64'(bus.bubble_cnt), 0);
        chk("rst_aluout", 64'(bus.mem_aluout), 0);
        mon_on = 1'b1;
        rst = 1'b1;

        // LW capture with one-cycle latency
        drive(0, 0, 1, 4'd8, 16'h5555, 16'h0040, 1);
        tick();
        chk("lw_aluout", 64'(bus.mem_aluout), 64'h0040);
        chk("lw_en", 64'(bus.Mem_En), 1);
        chk("lw_wr", 64'(bus.Mem_Wr), 0);
        chk("lw_rw", 64'(bus.mem_regwrite), 1);

        // SW held across three stall edges
        drive(0, 0, 1, 4'd9, 16'hAAAA, 16'h0100, 0);
        tick();
        drive(1, 0, 1, 4'd9, 16'h1234, 16'h0200, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_rd", 64'(bus.mem_regread1), 64'hAAAA);
            chk("stall_wr", 64'(bus.Mem_Wr), 1);
        end
        bus.stall = 1'b0;
        tick();
        chk("unstall_rd", 64'(bus.mem_regread1), 64'h1234);

        // Reset mid-stall with Mem_Wr set, then first load edge captures
        bus.stall = 1'b1;
        tick();
        mid_reset("rst_stall");
        drive(0, 0, 1, 4'd8, 16'h0001, 16'h0044, 1);
        tick();
        chk("post_rst_valid", 64'(bus.mem_valid), 1);
        chk("post_rst_alu", 64'(bus.mem_aluout), 64'h0044);

        // stall+flush together defers the flush to the next load edge
        drive(1, 1, 1, 4'd2, 16'h0777, 16'h0888, 1);
        tick();
        bus.stall = 1'b0; bus.flush = 1'b0;
        #1;
        chk("pend_ready", 64'(bus.ex_ready), 0);
        base = m_bc;
        tick();
        chk("pend_valid", 64'(bus.mem_valid), 0);
        chk("pend_bc", 64'(bus.bubble_cnt), 64'(16'(base + 1)));
        chk("pend_ready_after", 64'(bus.ex_ready), 1);

        // HLT with flush is dropped; HLT without flush halts
        drive(0, 1, 1, 4'd15, 16'h0, 16'h0, 0);
        tick();
        chk("hlt_flush_halted", 64'(bus.halted), 0);
        bus.flush = 1'b0;
        tick();
        chk("hlt_halted", 64'(bus.halted), 1);
        chk("hlt_ready", 64'(bus.ex_ready), 0);
        chk("hlt_valid", 64'(bus.mem_valid), 1);
        base = m_bc;
        drive(0, 0, 1, 4'd8, 16'h1111, 16'h2222, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_bubble", 64'(bus.mem_valid), 0);
        end
        chk("halt_bc5", 64'(bus.bubble_cnt), 64'(16'(base + 5)));
        mid_reset("rst_halt");
        tick();
        chk("halt_exit_valid", 64'(bus.mem_valid), 1);

        // Randomised traffic, occasionally resetting out of HALT
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                  16'($urandom), 16'($urandom), 1'($urandom));
            tick();
            if ((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0)
                mid_reset("rnd_rst");
        end

        // Bubble counter wrap
        drive(0, 0, 0, 4'd0, 16'd0, 16'd0, 0);
        for (int i = 0; i < 70000 && m_bc != 65535; i++) tick();
        chk("bc_ffff", 64'(bus.bubble_cnt), 64'hFFFF);
        tick();
        chk("bc_wrap", 64'(bus.bubble_cnt), 0);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
